cordic_polar_to_rect: RTL and testbench



---
 rtl/cordic_pkg.sv | 47 ++++
 rtl/cordic_polar_to_rect_atan_rom.sv | 13 +
 rtl/cordic_polar_to_rect.sv | 133 +++++++++++++
 tb/tb_cordic_polar_to_rect.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types, widths, arctangent table and saturation helper for the CORDIC block.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
    DONE
  } state_t;

  localparam int DW = 12;
  localparam int AW = 12;
  localparam int IW = DW + 4;

  // Binary-angle units: 2^AW per full turn
  function automatic logic [AW-1:0] atan_lut(input int i);
    logic [AW-1:0] a;
    a = '0;
    case (i)
      0:  a = AW'(512);
      1:  a = AW'(302);
      2:  a = AW'(160);
      3:  a = AW'(81);
      4:  a = AW'(41);
      5:  a = AW'(20);
      6:  a = AW'(10);
      7:  a = AW'(5);
      8:  a = AW'(3);
      9:  a = AW'(1);
      10: a = AW'(1);
      default: a = '0;
    endcase
    return a;
  endfunction

  // Symmetric clamp to +/-(2^(w-1)-1)
  function automatic logic signed [IW-1:0] saturate(
    input logic signed [IW-1:0] v,
    input int w
  );
    logic signed [IW-1:0] lim;
    lim = IW'((1 << (w - 1)) - 1);
    if (v > lim) return lim;
    else if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/cordic_polar_to_rect_atan_rom.sv
// Combinational lookup: iteration index -> arctangent step.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx,
  output logic [AW-1:0]    atan
);

  assign atan = atan_lut(int'(idx));

endmodule

// File: rtl/cordic_polar_to_rect.sv
// Iterative rotation-mode CORDIC, (r, theta) -> (x, y), one micro-rotation per clock.
// Optional CORDIC_ROUND_EN: round-half-up guard-bit removal instead of truncation.
module cordic_polar_to_rect
  import cordic_pkg::*;
#(
  parameter int WIDTH = DW,
  parameter int ANG_W = AW,
  parameter int ITER  = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mag,
  input  logic [ANG_W-1:0] in_ang,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic             busy
);

  localparam int IDX_W = $clog2(ITER + 1);
  localparam logic [ANG_W-1:0] HALF = ANG_W'(1) << (ANG_W - 1);
  localparam logic signed [ANG_W-1:0] QTR = ANG_W'(1) << (ANG_W - 2);
  localparam logic signed [IW-1:0] RND = IW'(2);

  state_t state, state_nx;

  logic [IDX_W-1:0] idx;
  logic signed [IW-1:0] x, y;
  logic signed [ANG_W-1:0] z;

  logic accept, last, dir;
  logic [AW-1:0] atan_i;
  logic signed [ANG_W-1:0] z_in, z0, z_rot;
  logic signed [IW-1:0] mag_ext, x0;
  logic signed [IW-1:0] xs, ys, x_rot, y_rot;
  logic signed [IW-1:0] x_drop, y_drop;
  logic signed [IW-1:0] x_sat, y_sat;

  cordic_atan_rom #(
    .IDX_W(IDX_W)
  ) u_rom (
    .idx (idx),
    .atan(atan_i)
  );

  assign accept = in_valid && in_ready;
  assign last   = (idx == IDX_W'(ITER));

  // Fold the left half-plane onto the right so the residual angle converges
  assign z_in    = signed'(in_ang);
  assign mag_ext = {{(IW-WIDTH-2){in_mag[WIDTH-1]}}, in_mag, 2'b00};

  always_comb begin
    x0 = mag_ext;
    z0 = z_in;
    if ((z_in > QTR) || (z_in < -QTR)) begin
      x0 = -mag_ext;
      z0 = signed'(in_ang - HALF);
    end
  end

  assign dir   = !z[ANG_W-1];
  assign xs    = x >>> idx;
  assign ys    = y >>> idx;
  assign x_rot = dir ? (x - ys) : (x + ys);
  assign y_rot = dir ? (y + xs) : (y - xs);
  assign z_rot = dir ? (z - signed'(atan_i))
                     : (z + signed'(atan_i));

`ifdef CORDIC_ROUND_EN
  assign x_drop = (x + RND) >>> 2;
  assign y_drop = (y + RND) >>> 2;
`else
  assign x_drop = x >>> 2;
  assign y_drop = y >>> 2;
`endif

  assign x_sat = saturate(x_drop, WIDTH);
  assign y_sat = saturate(y_drop, WIDTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept)    state_nx = ROTATE;
      ROTATE:  if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      x     <= '0;
      y     <= '0;
      z     <= '0;
      out_x <= '0;
      out_y <= '0;
    end else begin
      if (state == IDLE && accept) begin
        idx <= '0;
        x   <= x0;
        y   <= '0;
        z   <= z0;
      end else if (state == ROTATE) begin
        if (!last) begin
          idx <= idx + IDX_W'(1);
          x   <= x_rot;
          y   <= y_rot;
          z   <= z_rot;
        end else begin
          out_x <= WIDTH'(x_sat);
          out_y <= WIDTH'(y_sat);
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_polar_to_rect.sv
// Directed bench for cordic_polar_to_rect: vector table plus handshake and reset sequences.
module tb_cordic_polar_to_rect;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic [11:0] in_mag;
  logic [11:0] in_ang;
  logic out_valid;
  logic out_ready;
  logic signed [11:0] out_x;
  logic signed [11:0] out_y;
  logic busy;

  int checks = 0;
  int errors = 0;

  cordic_polar_to_rect dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mag   (in_mag),
    .in_ang   (in_ang),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_x    (out_x),
    .out_y    (out_y),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int mag;
    int ang;
    int ex;
    int ey;
    int tx;
    int ty;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int act,
                       input int exp, input int tol);
    int diff;
    checks++;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)",
               name, act, exp, tol);
    end
  endtask

  task automatic run(input int mag, input int ang,
                     output int rx, output int ry, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_mag   = mag[11:0];
    in_ang   = ang[11:0];
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    rx = int'(out_x);
    ry = int'(out_y);
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int rx, ry, lat, hx, hy, n;

    vecs[0] = '{1000,    0,  1646,     0, 4, 4};
    vecs[1] = '{1000, 1024,    -3,  1646, 4, 4};
    vecs[2] = '{1000, 2048, -1646,     0, 4, 4};
    vecs[3] = '{1000, 3072,    -3, -1646, 4, 4};
    vecs[4] = '{1000,  512,  1160,  1168, 4, 4};
    vecs[5] = '{-500,    0,  -823,     0, 4, 4};
    vecs[6] = '{1800,    0,  2047,     0, 0, 4};
    vecs[7] = '{-1800,   0, -2047,     0, 0, 4};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_mag    = '0;
    in_ang    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0, 0);
    check("rst_out_x", int'(out_x), 0, 0);
    check("rst_out_y", int'(out_y), 0, 0);
    check("rst_busy", int'(busy), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_in_ready", int'(in_ready), 1, 0);

    for (int i = 0; i < 8; i++) begin
      run(vecs[i].mag, vecs[i].ang, rx, ry, lat);
      check($sformatf("v%0d_latency", i), lat, 12, 0);
      check($sformatf("v%0d_x", i), rx, vecs[i].ex, vecs[i].tx);
      check($sformatf("v%0d_y", i), ry, vecs[i].ey, vecs[i].ty);
      check($sformatf("v%0d_no_ready", i), int'(in_ready), 0, 0);
      drain();
    end

    // Back-pressure: hold in DONE, poke in_valid, outputs must not move
    run(1000, 0, hx, hy, lat);
    check("bp_latency", lat, 12, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = c[0];
      in_mag   = 12'd123;
      in_ang   = 12'd1024;
      @(posedge clk);
      #1;
      check("bp_valid", int'(out_valid), 1, 0);
      check("bp_in_ready", int'(in_ready), 0, 0);
      check("bp_x_hold", int'(out_x), hx, 0);
      check("bp_y_hold", int'(out_y), hy, 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_rel_in_ready", int'(in_ready), 1, 0);
    check("bp_rel_valid", int'(out_valid), 0, 0);
    @(negedge clk);
    out_ready = 1'b0;
    run(1000, 1024, rx, ry, lat);
    check("bp_next_latency", lat, 12, 0);
    check("bp_next_y", ry, 1646, 4);
    drain();

    // Asynchronous reset in the middle of the rotation
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_mag   = 12'd1000;
    in_ang   = 12'd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0, 0);
    check("mid_rst_valid", int'(out_valid), 0, 0);
    check("mid_rst_x", int'(out_x), 0, 0);
    check("mid_rst_y", int'(out_y), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid_rst_in_ready", int'(in_ready), 1, 0);
    run(-500, 0, rx, ry, lat);
    check("post_rst_latency", lat, 12, 0);
    check("post_rst_x", rx, -823, 4);
    check("post_rst_y", ry, 0, 4);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
